// File: rtl/sha256_mem_responder.sv
// sha256_mem_responder
//
// Memory-side companion of the SHA-256 engine. It holds a word-addressed RAM that
// the engine reads and writes through its mem_* port with 1-cycle registered
// reads. A host port preloads message words and reads the digest back. A small
// run controller sequences eng_start/eng_done and reports hash completion.
//
// Optional feature macro: SHA_RESP_WATCHDOG_EN
//   When defined, a 32-bit cycle counter runs while the engine is launched or
//   running. Once it reaches TIMEOUT_CYCLES the controller returns to IDLE and
//   raises the sticky timeout_err output.
//
// Ports
//   clk, reset        single clock; asynchronous active-high reset
//   mem_addr/mem_we/mem_write_data/mem_read_data
//                     engine memory port, always served
//   eng_start/eng_done
//                     engine handshake
//   eng_message_addr/eng_output_addr
//                     constant base addresses for the engine
//   host_valid/host_ready/host_we/host_addr/host_wdata/host_rdata/host_rvalid
//                     host access port, accepted only while idle
//   run               level input; a rising edge while idle launches a hash
//   busy              high while a hash is in flight
//   hash_ready        sticky; all eight digest words were written
//   wr_count          digest-window writes seen in the current run (saturates at 8)
//   oob_err           sticky; an access addressed beyond the RAM
//   timeout_err       (watchdog build only) sticky; the engine never finished

module sha256_mem_responder #(
    parameter int unsigned DEPTH          = 256,
    parameter logic [15:0] MSG_BASE       = 16'h0000,
    parameter logic [15:0] OUT_BASE       = 16'h0080,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset,

    // Engine memory port
    input  logic [15:0] mem_addr,
    input  logic        mem_we,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,

    // Engine control
    output logic        eng_start,
    input  logic        eng_done,
    output logic [15:0] eng_message_addr,
    output logic [15:0] eng_output_addr,

    // Host port
    input  logic        host_valid,
    output logic        host_ready,
    input  logic        host_we,
    input  logic [15:0] host_addr,
    input  logic [31:0] host_wdata,
    output logic [31:0] host_rdata,
    output logic        host_rvalid,

    // Run control and status
    input  logic        run,
    output logic        busy,
    output logic        hash_ready,
    output logic [3:0]  wr_count,
`ifdef SHA_RESP_WATCHDOG_EN
    output logic        oob_err,
    output logic        timeout_err
`else
    output logic        oob_err
`endif
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StRun,
        StFinish
    } state_e;

    state_e state_q;
    logic   run_q;

    logic [31:0] ram [DEPTH];

    logic          mem_in_range;
    logic          host_in_range;
    logic          mem_in_win;
    logic          host_fire;
    logic [AW-1:0] mem_idx;
    logic [AW-1:0] host_idx;

    assign eng_message_addr = MSG_BASE;
    assign eng_output_addr  = OUT_BASE;

    assign mem_in_range  = (32'(mem_addr) < DEPTH);
    assign host_in_range = (32'(host_addr) < DEPTH);
    assign mem_idx       = mem_addr[AW-1:0];
    assign host_idx      = host_addr[AW-1:0];

    // Digest window compared at 17 bits so OUT_BASE near the top cannot wrap.
    assign mem_in_win = ({1'b0, mem_addr} >= {1'b0, OUT_BASE}) &&
                        ({1'b0, mem_addr} <  ({1'b0, OUT_BASE} + 17'd8));

    // Host is only served while idle; held low during reset so every output is 0.
    assign host_ready = (state_q == StIdle) && !reset;
    assign host_fire  = host_valid && host_ready;

    // ------------------------------------------------------------------
    // RAM storage (contents are not reset). The engine is idle whenever the
    // host can write, so the two write ports never target the array together
    // in normal operation.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (mem_we && mem_in_range) begin
            ram[mem_idx] <= mem_write_data;
        end
        if (host_fire && host_we && host_in_range) begin
            ram[host_idx] <= host_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Registered read paths and the out-of-range flag. Non-blocking reads of
    // the array give read-first behaviour on a same-cycle write.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_read_data <= 32'd0;
            host_rdata    <= 32'd0;
            host_rvalid   <= 1'b0;
            oob_err       <= 1'b0;
        end else begin
            mem_read_data <= mem_in_range ? ram[mem_idx] : 32'd0;

            host_rvalid <= host_fire && !host_we;
            if (host_fire && !host_we) begin
                host_rdata <= host_in_range ? ram[host_idx] : 32'd0;
            end

            // The engine port is sampled every cycle, so its address counts too.
            if (!mem_in_range || (host_fire && !host_in_range)) begin
                oob_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Run controller with registered outputs.
    // ------------------------------------------------------------------
`ifdef SHA_RESP_WATCHDOG_EN
    logic [31:0] wd_cnt_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            run_q       <= 1'b0;
            eng_start   <= 1'b0;
            busy        <= 1'b0;
            hash_ready  <= 1'b0;
            wr_count    <= 4'd0;
`ifdef SHA_RESP_WATCHDOG_EN
            wd_cnt_q    <= 32'd0;
            timeout_err <= 1'b0;
`endif
        end else begin
            run_q <= run;

            unique case (state_q)
                StIdle: begin
                    // Only a fresh rising edge launches; a held level does not.
                    if (run && !run_q) begin
                        state_q    <= StLaunch;
                        eng_start  <= 1'b1;
                        busy       <= 1'b1;
                        hash_ready <= 1'b0;
                        wr_count   <= 4'd0;
`ifdef SHA_RESP_WATCHDOG_EN
                        wd_cnt_q    <= 32'd0;
                        timeout_err <= 1'b0;
`endif
                    end
                end

                StLaunch: begin
                    // Engine acknowledges the start by dropping done.
                    if (!eng_done) begin
                        state_q   <= StRun;
                        eng_start <= 1'b0;
                    end
                end

                StRun: begin
                    if (mem_we && mem_in_win && (wr_count != 4'd8)) begin
                        wr_count <= wr_count + 4'd1;
                    end
                    if (eng_done) begin
                        state_q <= StFinish;
                    end
                end

                StFinish: begin
                    hash_ready <= (wr_count == 4'd8);
                    busy       <= 1'b0;
                    state_q    <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase

`ifdef SHA_RESP_WATCHDOG_EN
            // Overrides the case above when the engine has taken too long.
            if ((state_q == StLaunch) || (state_q == StRun)) begin
                if (wd_cnt_q >= (TIMEOUT_CYCLES - 32'd1)) begin
                    state_q     <= StIdle;
                    eng_start   <= 1'b0;
                    busy        <= 1'b0;
                    timeout_err <= 1'b1;
                    wd_cnt_q    <= 32'd0;
                end else begin
                    wd_cnt_q <= wd_cnt_q + 32'd1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_sha256_mem_responder.sv
module tb_sha256_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        eng_start;
    logic        eng_done;
    logic [15:0] eng_message_addr;
    logic [15:0] eng_output_addr;
    logic        host_valid;
    logic        host_ready;
    logic        host_we;
    logic [15:0] host_addr;
    logic [31:0] host_wdata;
    logic [31:0] host_rdata;
    logic        host_rvalid;
    logic        run;
    logic        busy;
    logic        hash_ready;
    logic [3:0]  wr_count;
    logic        oob_err;
`ifdef SHA_RESP_WATCHDOG_EN
    logic        timeout_err;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    sha256_mem_responder dut (
        .clk              (clk),
        .reset            (reset),
        .mem_addr         (mem_addr),
        .mem_we           (mem_we),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data),
        .eng_start        (eng_start),
        .eng_done         (eng_done),
        .eng_message_addr (eng_message_addr),
        .eng_output_addr  (eng_output_addr),
        .host_valid       (host_valid),
        .host_ready       (host_ready),
        .host_we          (host_we),
        .host_addr        (host_addr),
        .host_wdata       (host_wdata),
        .host_rdata       (host_rdata),
        .host_rvalid      (host_rvalid),
        .run              (run),
        .busy             (busy),
        .hash_ready       (hash_ready),
        .wr_count         (wr_count),
`ifdef SHA_RESP_WATCHDOG_EN
        .oob_err          (oob_err),
        .timeout_err      (timeout_err)
`else
        .oob_err          (oob_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every host read response pops one expected word.
    always @(negedge clk) begin
        if (!reset && host_rvalid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL host_rvalid_unexpected: got rdata %h expected no response",
                         host_rdata);
            end else begin
                chk("host_rdata", host_rdata, exp_q.pop_front());
            end
        end
    end

    // All tasks start and end at posedge + 1.
    task automatic host_write(input logic [15:0] a, input logic [31:0] d);
        host_valid = 1'b1;
        host_we    = 1'b1;
        host_addr  = a;
        host_wdata = d;
        @(posedge clk); #1;
        host_valid = 1'b0;
        host_we    = 1'b0;
    endtask

    task automatic host_read(input logic [15:0] a, input logic [31:0] exp);
        host_valid = 1'b1;
        host_we    = 1'b0;
        host_addr  = a;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        host_valid = 1'b0;
    endtask

    // Engine model: acknowledges start one cycle late, writes n digest words
    // (wrapping within the window) plus one word outside it, then signals done.
    task automatic do_hash(input int n, input logic [31:0] seed);
        run      = 1'b0;
        eng_done = 1'b1;
        @(posedge clk); #1;
        run = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (eng_start) break;
        end
        chk("eng_start_rise", {31'd0, eng_start}, 32'd1);
        chk("busy_launch", {31'd0, busy}, 32'd1);
        chk("hash_ready_cleared", {31'd0, hash_ready}, 32'd0);
        @(posedge clk); #1;
        chk("eng_start_hold", {31'd0, eng_start}, 32'd1);
        eng_done = 1'b0;
        @(posedge clk); #1;
        chk("eng_start_drop", {31'd0, eng_start}, 32'd0);
        for (int i = 0; i < n; i++) begin
            mem_we         = 1'b1;
            mem_addr       = 16'h0080 + 16'(i % 8);
            mem_write_data = seed + 32'(i);
            @(posedge clk); #1;
        end
        mem_addr       = 16'h0040;
        mem_write_data = 32'hEEEE_0040;
        @(posedge clk); #1;
        mem_we   = 1'b0;
        mem_addr = 16'h0000;
        eng_done = 1'b1;
        @(posedge clk); #1;
        chk("busy_finish", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        chk("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset          = 1'b1;
        mem_addr       = 16'h0000;
        mem_we         = 1'b0;
        mem_write_data = 32'd0;
        eng_done       = 1'b1;
        host_valid     = 1'b0;
        host_we        = 1'b0;
        host_addr      = 16'h0000;
        host_wdata     = 32'd0;
        run            = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("host_ready_in_reset", {31'd0, host_ready}, 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_eng_start", {31'd0, eng_start}, 32'd0);
        chk("rst_hash_ready", {31'd0, hash_ready}, 32'd0);
        chk("rst_wr_count", {28'd0, wr_count}, 32'd0);
        chk("rst_oob", {31'd0, oob_err}, 32'd0);
        chk("rst_rvalid", {31'd0, host_rvalid}, 32'd0);
        chk("rst_mem_rdata", mem_read_data, 32'd0);
        chk("host_ready_idle", {31'd0, host_ready}, 32'd1);
        chk("msg_addr", {16'd0, eng_message_addr}, 32'h0000_0000);
        chk("out_addr", {16'd0, eng_output_addr}, 32'h0000_0080);
        @(posedge clk); #1;

        // Host preload and readback
        for (int i = 0; i < 20; i++) host_write(16'(i), 32'hA5A5_0000 + 32'(i));
        host_read(16'd5, 32'hA5A5_0005);
        host_read(16'd19, 32'hA5A5_0013);

        // Engine read-first on same-cycle write
        mem_addr       = 16'd3;
        mem_we         = 1'b1;
        mem_write_data = 32'h0000_1234;
        @(posedge clk); #1;
        chk("read_first_old", mem_read_data, 32'hA5A5_0003);
        mem_we = 1'b0;
        @(posedge clk); #1;
        chk("read_after_write", mem_read_data, 32'h0000_1234);
        mem_addr = 16'h0000;
        host_read(16'd3, 32'h0000_1234);

        // Full digest
        do_hash(8, 32'hD000_0000);
        chk("full_hash_ready", {31'd0, hash_ready}, 32'd1);
        chk("full_wr_count", {28'd0, wr_count}, 32'd8);
        // run still high: no relaunch
        repeat (5) @(posedge clk);
        #1;
        chk("no_relaunch_busy", {31'd0, busy}, 32'd0);
        chk("no_relaunch_start", {31'd0, eng_start}, 32'd0);
        run = 1'b0;
        host_read(16'h0080, 32'hD000_0000);
        host_read(16'h0087, 32'hD000_0007);
        host_read(16'h0040, 32'hEEEE_0040);

        // Saturation: 10 window writes
        do_hash(10, 32'hC000_0000);
        chk("sat_wr_count", {28'd0, wr_count}, 32'd8);
        chk("sat_hash_ready", {31'd0, hash_ready}, 32'd1);
        host_read(16'h0081, 32'hC000_0009);

        // Partial digest
        do_hash(7, 32'hB000_0000);
        chk("partial_hash_ready", {31'd0, hash_ready}, 32'd0);
        chk("partial_wr_count", {28'd0, wr_count}, 32'd7);
        run = 1'b0;
        host_read(16'h0086, 32'hB000_0006);
        host_read(16'h0087, 32'hC000_0007);

        // Out of range
        chk("oob_before", {31'd0, oob_err}, 32'd0);
        host_write(16'h0100, 32'hFFFF_FFFF);
        chk("oob_after_write", {31'd0, oob_err}, 32'd1);
        host_read(16'h0100, 32'h0000_0000);
        host_read(16'h0000, 32'hA5A5_0000);

        // Reset while launching
        run = 1'b1;
        @(posedge clk); #1;
        chk("launch_start", {31'd0, eng_start}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_launch_start", {31'd0, eng_start}, 32'd0);
        chk("rst_launch_busy", {31'd0, busy}, 32'd0);
        #2 reset = 1'b0;
        run = 1'b0;
        @(posedge clk); #1;

        // Reset while running
        run = 1'b1;
        @(posedge clk); #1;
        eng_done = 1'b0;
        @(posedge clk); #1;
        mem_we         = 1'b1;
        mem_addr       = 16'h0080;
        mem_write_data = 32'hDEAD_0000;
        @(posedge clk); #1;
        mem_we   = 1'b0;
        mem_addr = 16'h0000;
        chk("run_wr_count", {28'd0, wr_count}, 32'd1);
        chk("run_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_run_start", {31'd0, eng_start}, 32'd0);
        chk("rst_run_busy", {31'd0, busy}, 32'd0);
        chk("rst_run_hash_ready", {31'd0, hash_ready}, 32'd0);
        chk("rst_run_wr_count", {28'd0, wr_count}, 32'd0);
        #2 reset = 1'b0;
        run      = 1'b0;
        eng_done = 1'b1;
        @(posedge clk); #1;
        host_read(16'h0080, 32'hDEAD_0000);
        host_read(16'h0005, 32'hA5A5_0005);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
